// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed display scanner.
// Segment vectors are active-low, bit6 = a ... bit0 = g.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        SHOW,
        BLANK
    } scan_state_t;

    // Table is written as lit segments (1 = on) and inverted on return.
    function automatic seg_t hex_seg(input logic [3:0] nib);
        seg_t lit;
        case (nib)
            4'h0:    lit = 7'b1111110;
            4'h1:    lit = 7'b0110000;
            4'h2:    lit = 7'b1101101;
            4'h3:    lit = 7'b1111001;
            4'h4:    lit = 7'b0110011;
            4'h5:    lit = 7'b1011011;
            4'h6:    lit = 7'b1011111;
            4'h7:    lit = 7'b1110000;
            4'h8:    lit = 7'b1111111;
            4'h9:    lit = 7'b1111011;
            4'hA:    lit = 7'b1110111;
            4'hB:    lit = 7'b0011111;
            4'hC:    lit = 7'b1001110;
            4'hD:    lit = 7'b0111101;
            4'hE:    lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder, shared by all digits.
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_seg(nib);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode display scanner with tear-free, frame-aligned updates.
// One decoder is time-shared; an/seg are registered one cycle behind state/idx.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZB          = 0
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   upd_digits,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic                    upd_ack,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg
);

    localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    scan_state_t            state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic                   first_reg, first_next;
    logic                   frame_start;

    logic [4*N_DIGITS-1:0]  shadow_reg;
    logic [4*N_DIGITS-1:0]  staged_reg;
    logic                   pending_reg;
    logic                   ack_reg;
    logic [N_DIGITS-1:0]    an_reg, an_next;
    seg_t                   seg_reg, seg_next;

    logic [3:0]             nib [N_DIGITS];
    logic [N_DIGITS-1:0]    nib_zero;
    logic [N_DIGITS-1:0]    upper_zero;
    logic                   zero_acc;
    logic                   visible;
    logic [6:0]             dec_seg;

    // Scan sequencer; first_reg holds idx at 0 across the first frame start after reset.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 1'b1;
        idx_next    = idx_reg;
        first_next  = first_reg;
        frame_start = 1'b0;
        case (state_reg)
            SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                end
            end
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                    first_next = 1'b0;
                    if (first_reg || idx_reg == IDX_LAST) begin
                        idx_next    = '0;
                        frame_start = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
            assign nib[gi]      = shadow_reg[4*gi +: 4];
            assign nib_zero[gi] = (nib[gi] == 4'h0);
        end
    endgenerate

    // upper_zero[i]: digits i..N_DIGITS-1 are all zero (leading zeros from digit i up).
    always_comb begin
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc & nib_zero[i];
            upper_zero[i] = zero_acc;
        end
    end

    hex_to_7seg u_dec (
        .nib (nib[idx_reg]),
        .seg (dec_seg)
    );

    always_comb begin
        visible  = digit_en[idx_reg]
                   && !((LZB != 0) && (idx_reg != '0) && upper_zero[idx_reg]);
        an_next  = '1;
        seg_next = SEG_BLANK;
        if (state_reg == SHOW && visible) begin
            an_next  = ~(N_DIGITS'(1) << idx_reg);
            seg_next = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= BLANK;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            first_reg   <= 1'b1;
            shadow_reg  <= '0;
            staged_reg  <= '0;
            pending_reg <= 1'b0;
            ack_reg     <= 1'b0;
            an_reg      <= '1;
            seg_reg     <= SEG_BLANK;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            first_reg <= first_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            ack_reg   <= 1'b0;
            // Apply needs pending, accept needs !pending, so they never coincide.
            if (frame_start && pending_reg) begin
                shadow_reg  <= staged_reg;
                pending_reg <= 1'b0;
                ack_reg     <= 1'b1;
            end else if (upd_valid && !pending_reg) begin
                staged_reg  <= upd_digits;
                pending_reg <= 1'b1;
            end
        end
    end

    assign upd_ready = !pending_reg;
    assign upd_ack   = ack_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes one hex-to-7-segment decoder across N_DIGITS common-anode digits, driving an active-low anode-select bus and a shared active-low segment bus.
- Accepts new display values through a valid/ready handshake. Applies them only at frame boundaries, so a frame never mixes old and new values (no tearing).
- Sits between the datapath producing BCD/hex values and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
SHOW_CYCLES, 50000, clk cycles each digit is driven per frame
BLANK_CYCLES, 500, clk cycles with all anodes off between digits (anti-ghosting, >=1)
LZB, 0, 1 = leading-zero blanking enabled

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
upd_digits  input  4*N_DIGITS  new values, nibble i = digit i (digit 0 = rightmost, LSBs)
upd_valid  input  1  producer offers upd_digits
upd_ready  output  1  block can accept an update
upd_ack  output  1  one-cycle pulse: staged update now displayed
digit_en  input  N_DIGITS  per-digit enable mask, sampled live
an  output  N_DIGITS  anode select, active-low, at most one bit low
seg  output  7  segments, active-low, bit6=a ... bit0=g

Behaviour:
- Reset (async assert, sync release): state=BLANK, cnt=0, idx=0, shadow=0, staged=0, pending=0, an=all 1, seg=7'h7F, upd_ack=0. upd_ready=1 after reset.
- Mid-operation reset drops any pending update; display restarts at digit 0.
- upd_ready = !pending (combinational from register).
  - upd_valid && upd_ready in a cycle -> staged <= upd_digits, pending <= 1 at that edge.
  - upd_valid while pending -> ignored; staged is unchanged and the producer holds.
- FSM, one shared down/up counter cnt:
  - SHOW: counts 0..SHOW_CYCLES-1, then -> BLANK with cnt=0.
  - BLANK: counts 0..BLANK_CYCLES-1, then -> SHOW with cnt=0 and idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
  - Exception: the first BLANK->SHOW after reset keeps idx=0.
- Frame boundary = BLANK->SHOW transition in which idx becomes 0, including the first one after reset. At this edge, if pending:
  - shadow <= staged
  - pending <= 0
  - upd_ack = 1 for exactly that cycle
- Accept-and-apply collision cannot occur: ready is 0 while pending. A new offer is accepted no earlier than the cycle after apply.
- Outputs are registered, 1 cycle after the state/idx they reflect:
  - SHOW, digit visible: an = ~(1<<idx), seg = hex_to_7seg(shadow[idx]).
  - BLANK, or digit not visible: an = all 1, seg = 7'h7F.
- Digit visible = digit_en[idx] && !(LZB && idx>0 && shadow[N_DIGITS-1:idx] nibbles all zero). Digit 0 is never zero-blanked.
- Disabled or blanked digits still consume their full SHOW slot, so brightness of the other digits is unchanged.
- Frame period = N_DIGITS*(SHOW_CYCLES+BLANK_CYCLES) clk cycles, fixed.
- Decoder encoding, a..g, 1 = lit, output inverted:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111

Decomposition:
- Package disp_pkg:
  - typedef seg_t (logic [6:0])
  - localparam SEG_BLANK = 7'h7F
  - enum scan_state_t {SHOW, BLANK}
  - function/constant table for hex nibble -> seg_t
- Sub-module hex_to_7seg: purely combinational, 4-bit in, seg_t active-low out, table from disp_pkg. It is instantiated once and shared; the controller muxes shadow[idx] into it.

Test Plan (bench params N_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1, LZB=0 unless noted):
1. Reset and release, digit_en=4'hF: an=4'b1111 and seg=7'h7F during reset; upd_ready=1. First SHOW of digit 0 (shadow=0) gives an=4'b1110, seg=7'b0000001.
2. Offer 16'h1234 for one cycle while upd_ready=1:
   - upd_ready drops the next cycle.
   - upd_ack pulses at the next frame boundary.
   - Following frame: digit0 seg=7'b1001100 (4), digit1 seg=7'b0000110 (3), digit2 seg=7'b0010010 (2), digit3 seg=7'b1001111 (1).
   - an walks 1110, 1101, 1011, 0111.
3. Timing:
   - Each anode stays low exactly 4 cycles, followed by 1 cycle with an=4'b1111.
   - Frame period 20 cycles; the interval between successive upd_ack (back-to-back updates) is a multiple of 20.
4. Back-pressure:
   - While pending, offer 16'hFFFF with upd_valid held: not accepted; the old value stays displayed.
   - After upd_ack, 16'hFFFF is accepted. Next ack, then all digits show F (seg=7'b0111000).
5. LZB=1, value 16'h0007: digits 3..1 keep an high during their slots; digit0 shows seg=7'b0001111. digit_en=4'b1110 additionally blanks digit0 with unchanged timing.
6. Assert rst_n=0 during SHOW of digit 2 with an update pending:
   - an=4'b1111 and seg=7'h7F immediately (async).
   - After release, upd_ack never fires for the dropped update; digit 0 shows 0.
